// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot program loader.
// The loader takes the slave side; the host/bench takes the master side.
interface instr_loader_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic                     start;
  logic [7:0]               byte_in;
  logic                     byte_valid;
  logic                     byte_ready;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic                     cpu_hold;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, we, waddr, wdata, busy, done, err, cpu_hold
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, we, waddr, wdata, busy, done, err, cpu_hold
  );
endinterface

// File: rtl/instr_loader.sv
// Boot-time loader: a length byte followed by little-endian 32-bit words is written into
// instruction memory, and the CPU is held until a complete program has landed.
module instr_loader #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_loader_if.slave bus
);
  localparam int unsigned CAPACITY = 2**(ADDRESS_WIDTH-2);
  localparam int          WIDX_W   = ADDRESS_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [7:0]               r_len;
  logic [WIDX_W-1:0]        r_word_idx;
  logic [WIDX_W-1:0]        w_word_inc;
  logic [1:0]               r_byte_idx;
  logic [DATA_WIDTH-1:0]    r_asm;
  logic [DATA_WIDTH-1:0]    w_asm;
  logic                     r_byte_ready;
  logic                     r_we;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;
  logic                     r_cpu_hold;
  logic [ADDRESS_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     w_accept;
  logic                     w_last_word;

  // Output flags per state, packed as {byte_ready, busy, done, err, cpu_hold}.
  function automatic logic [4:0] flags_of(input state_t s);
    case (s)
      S_LEN, S_DATA: flags_of = 5'b11001;
      S_WRITE:       flags_of = 5'b01001;
      S_DONE:        flags_of = 5'b00100;
      S_ERR:         flags_of = 5'b00011;
      default:       flags_of = 5'b00001;
    endcase
  endfunction

  assign w_accept    = bus.byte_valid && r_byte_ready;
  assign w_word_inc  = r_word_idx + {{(WIDX_W-1){1'b0}}, 1'b1};
  assign w_last_word = (32'(w_word_inc) == 32'(r_len));

  // Merge the incoming byte into the partially assembled word at its little-endian lane.
  always_comb begin
    w_asm = r_asm;
    w_asm[{r_byte_idx, 3'b000} +: 8] = bus.byte_in;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) w_next = S_LEN;
        else           w_next = r_state;
      end
      S_LEN: begin
        if (w_accept) begin
          if (bus.byte_in == 8'd0)                 w_next = S_DONE;
          else if (32'(bus.byte_in) > CAPACITY)    w_next = S_ERR;
          else                                     w_next = S_DATA;
        end else begin
          w_next = S_LEN;
        end
      end
      S_DATA: begin
        if (w_accept && (r_byte_idx == 2'd3)) w_next = S_WRITE;
        else                                  w_next = S_DATA;
      end
      S_WRITE: begin
        if (w_last_word) w_next = S_DONE;
        else             w_next = S_DATA;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, registered Moore outputs and the word-assembly datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= 8'd0;
      r_word_idx   <= {WIDX_W{1'b0}};
      r_byte_idx   <= 2'd0;
      r_asm        <= {DATA_WIDTH{1'b0}};
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_waddr      <= {ADDRESS_WIDTH{1'b0}};
      r_wdata      <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state <= w_next;
      {r_byte_ready, r_busy, r_done, r_err, r_cpu_hold} <= flags_of(w_next);
      r_we    <= (w_next == S_WRITE);
      case (r_state)
        S_LEN: begin
          if (w_accept) begin
            r_len      <= bus.byte_in;
            r_word_idx <= {WIDX_W{1'b0}};
            r_byte_idx <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_asm      <= w_asm;
            r_byte_idx <= r_byte_idx + 2'd1;
            // waddr/wdata only change when a complete word is ready to be written.
            if (r_byte_idx == 2'd3) begin
              r_wdata <= w_asm;
              r_waddr <= {r_word_idx[ADDRESS_WIDTH-3:0], 2'b00};
            end
          end
        end
        S_WRITE: r_word_idx <= w_word_inc;
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.we         = r_we;
  assign bus.waddr      = r_waddr;
  assign bus.wdata      = r_wdata;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.cpu_hold   = r_cpu_hold;
endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader that writes the instruction memory on behalf of the host: accepts a byte stream over a valid/ready handshake, takes a one-byte word count followed by little-endian 32-bit instruction words, and issues one word write per instruction into the instruction memory write port. It sits beside the fetch path. It holds the CPU halted through `cpu_hold` until a complete program has been written, and only then releases the core to fetch from PC 0.

## Interface
- `ADDRESS_WIDTH`, 8, byte-address width of instruction memory; capacity is `2**(ADDRESS_WIDTH-2)` words (64 at default).
- `DATA_WIDTH`, 32, instruction word width; fixed at 32 (4 bytes per word).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a load; honoured only in IDLE, DONE or ERR.
- `byte_in` in 8: stream byte.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `we` out 1: instruction memory write enable, one-cycle pulse per word.
- `waddr` out ADDRESS_WIDTH: byte address of the write, always word-aligned (`[1:0]==0`).
- `wdata` out DATA_WIDTH: instruction word to write.
- `busy` out 1: high in LEN, DATA and WRITE.
- `done` out 1: high in DONE.
- `err` out 1: high in ERR.
- `cpu_hold` out 1: keeps the CPU halted; low only in DONE.

## Operation
- A byte is accepted on any rising edge where `byte_valid && byte_ready`. `byte_ready` is a Moore output: 1 in LEN and DATA, 0 elsewhere.
- **States:**
  - **IDLE:** the reset state. `start` moves it to LEN.
  - **LEN:**
    - On byte accept, latch N = `byte_in` and clear `word_idx` and `byte_idx`.
    - N==0 goes to DONE.
    - N > `2**(ADDRESS_WIDTH-2)` goes to ERR.
    - Any other N goes to DATA.
  - **DATA:**
    - The accepted byte is stored at `wdata_reg[8*byte_idx +: 8]` (little-endian), and `byte_idx` increments modulo 4.
    - Accepting the byte with `byte_idx==3` moves to WRITE.
  - **WRITE:**
    - Outputs: `we`=1, `waddr = word_idx << 2`, `wdata` = assembled word.
    - At the end of the cycle `word_idx` increments.
    - If the incremented `word_idx == N`, go to DONE; otherwise go to DATA.
  - **DONE:** `done`=1 and `cpu_hold`=0. `start` moves to LEN and re-asserts `cpu_hold`.
  - **ERR:** `err`=1. No write has occurred and `cpu_hold` stays high. `start` moves to LEN.
- `start` in LEN, DATA or WRITE is ignored. `byte_valid` in IDLE, WRITE, DONE or ERR is ignored: the byte is not consumed because `byte_ready`=0.
- `word_idx` is ADDRESS_WIDTH-1 bits wide, so N = 64 is representable. `waddr` is `word_idx[ADDRESS_WIDTH-3:0] << 2` and never wraps inside a valid load.
- Memory contents beyond word N-1 are left untouched.
- A reset mid-load returns to IDLE and discards the partial word. Words already written stay in memory.

## Timing
- Reset values:
  - State IDLE.
  - `byte_ready`=0, `we`=0, `waddr`=0, `wdata`=0.
  - `busy`=0, `done`=0, `err`=0.
  - `cpu_hold`=1.
- `start` sampled at edge t puts the block in LEN from cycle t+1, so `byte_ready`=1 in that cycle.
- The 4th byte of a word is accepted at edge t. WRITE, with `we`=1, is active in cycle t+1. The write lands at edge t+2.
  - If that word is the last one, `done`=1 and `cpu_hold`=0 from cycle t+2.
  - Otherwise `byte_ready` returns to 1 in cycle t+2.
- Peak throughput is 1 word per 5 cycles: 4 accepts plus 1 write. Gaps in `byte_valid` stall without loss.
- `waddr` and `wdata` are registered and hold their last values outside WRITE. Consumers qualify them with `we` only.
- An async reset assertion during WRITE deasserts `we` immediately.

## Test plan
- **Two-word load:** reset; `start`; stream 0x02, 0x13,0x05,0x10,0x00, 0x93,0x05,0xF0,0xFF with `byte_valid` held.
  - Required: `we` pulses at `waddr` 0x00 with `wdata` 0x00100513, then at 0x04 with 0xFFF00593.
  - `done`=1 and `cpu_hold`=0 two cycles after the last accept.
- **Zero length:** `start`, byte 0x00 → DONE the next cycle, no `we` pulse, `cpu_hold`=0.
- **Overflow:** `start`, byte 0x41 (65) at ADDRESS_WIDTH=8 → ERR, `err`=1, no `we`, `cpu_hold`=1. A following `start` then 0x01 plus 4 bytes loads correctly and clears `err`.
- **Full memory:** N=64 with word k = k → 64 `we` pulses at `waddr` 0x00..0xFC, the last with `wdata` 0x0000003F, then `done`.
- **Bursty valid and ignored start:** `byte_valid` toggled randomly, and `start` pulsed mid-load → identical writes to the continuous case, no restart, each byte consumed exactly once.
- **Reset mid-load:** assert `rst_n`=0 after 2 of 4 data bytes → all outputs at reset values. A restarted load of 1 word writes address 0x00 with the new data only.
